// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding and the opcode bit that marks a two-byte instruction.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_HOLD      = 3'd3,
    ST_HALTED    = 3'd4
  } fetch_state_t;

  localparam int OP_IMM_BIT = 7;

  // An opcode with its top bit set carries one immediate byte after it.
  function automatic logic has_imm(input logic [7:0] opcode);
    return opcode[OP_IMM_BIT];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Holding register for the instruction being assembled: opcode, operand
// and the address of the opcode byte. Clear wins over hold, hold wins
// over the two load strobes.
module fetch_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             load_op,
  input  logic             load_imm,
  input  logic [7:0]       data,
  input  logic [WIDTH-1:0] pc_adr,
  output logic [7:0]       opcode,
  output logic [7:0]       operand,
  output logic [WIDTH-1:0] adr
);

  // Capture opcode/address on the first byte (operand zeroed so one-byte
  // instructions read 0x00), capture the operand on the second byte.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      opcode  <= 8'h00;
      operand <= 8'h00;
      adr     <= '0;
    end else if (!hold) begin
      if (load_op) begin
        opcode  <= data;
        operand <= 8'h00;
        adr     <= pc_adr;
      end else if (load_imm) begin
        operand <= data;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads one- or two-byte instructions from
// instruction memory at the external program counter, presents them to
// decode with a valid/ready handshake, and handles branches and halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_crnt_adr,
  output logic             pc_enable,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_nxt_adr,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_adr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [7:0]       instr_opcode,
  output logic [7:0]       instr_operand,
  output logic [WIDTH-1:0] instr_adr,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic buf_clear;
  logic buf_hold;
  logic buf_load_op;
  logic buf_load_imm;

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, memory request and buffer controls. A branch overrides
  // any fetch progress; reset overrides everything, branch included.
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    instr_valid  = 1'b0;
    buf_clear    = 1'b0;
    buf_hold     = 1'b0;
    buf_load_op  = 1'b0;
    buf_load_imm = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = halt ? ST_HALTED : ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          buf_load_op = 1'b1;
          state_nxt   = has_imm(mem_rdata) ? ST_FETCH_IMM : ST_HOLD;
        end
      end
      ST_FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          buf_load_imm = 1'b1;
          state_nxt    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        buf_hold    = 1'b1;
        if (instr_ready) begin
          state_nxt = halt ? ST_HALTED : ST_FETCH_OP;
        end
      end
      ST_HALTED: begin
        if (!halt) begin
          state_nxt = ST_FETCH_OP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (br_valid) begin
      state_nxt    = ST_FETCH_OP;
      buf_clear    = 1'b1;
      buf_load_op  = 1'b0;
      buf_load_imm = 1'b0;
    end

    if (reset) begin
      state_nxt    = ST_IDLE;
      mem_req      = 1'b0;
      instr_valid  = 1'b0;
      buf_clear    = 1'b1;
      buf_load_op  = 1'b0;
      buf_load_imm = 1'b0;
    end
  end

  // An acknowledged byte advances the PC unless a branch steals the cycle.
  assign pc_enable  = mem_req & mem_ack & ~br_valid;
  assign pc_load    = br_valid & ~reset;
  assign pc_nxt_adr = pc_load ? br_target : '0;
  assign mem_adr    = pc_crnt_adr;

  fetch_buf #(
    .WIDTH (WIDTH)
  ) u_fetch_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (buf_clear),
    .hold     (buf_hold),
    .load_op  (buf_load_op),
    .load_imm (buf_load_imm),
    .data     (mem_rdata),
    .pc_adr   (pc_crnt_adr),
    .opcode   (instr_opcode),
    .operand  (instr_operand),
    .adr      (instr_adr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the program counter and instruction
// memory, keeps a transaction-level reference of the instruction being
// assembled, and compares every output on every falling edge.
module tb_fetch_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] pc_crnt_adr;
  logic             pc_enable;
  logic             pc_load;
  logic [WIDTH-1:0] pc_nxt_adr;
  logic             mem_req;
  logic [WIDTH-1:0] mem_adr;
  logic             mem_ack;
  logic [7:0]       mem_rdata;
  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       instr_opcode;
  logic [7:0]       instr_operand;
  logic [WIDTH-1:0] instr_adr;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             halt;

  logic [7:0] mem [0:255];

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_crnt_adr   (pc_crnt_adr),
    .pc_enable     (pc_enable),
    .pc_load       (pc_load),
    .pc_nxt_adr    (pc_nxt_adr),
    .mem_req       (mem_req),
    .mem_adr       (mem_adr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_operand (instr_operand),
    .instr_adr     (instr_adr),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .halt          (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: program counter and combinational instruction memory.
  always @(posedge clk) begin
    if (reset) pc_crnt_adr <= '0;
    else if (pc_load) pc_crnt_adr <= pc_nxt_adr;
    else if (pc_enable) pc_crnt_adr <= pc_crnt_adr + 1'b1;
  end
  assign mem_rdata = mem[pc_crnt_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: bytes collected for the current instruction.
  bit         armed   = 0;
  bit         started = 0;
  bit         halted  = 0;
  logic [7:0] got [$];
  logic [7:0] got_adr = '0;

  function automatic bit complete();
    int need;
    if (got.size() == 0) return 0;
    need = got[0][7] ? 2 : 1;
    return got.size() == need;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      armed = 1; started = 0; halted = 0; got.delete();
    end else if (armed) begin
      if (br_valid) begin
        started = 1; halted = 0; got.delete();
      end else if (!started) begin
        started = 1; halted = halt;
      end else if (halted) begin
        if (!halt) halted = 0;
      end else if (complete()) begin
        if (instr_ready) begin got.delete(); halted = halt; end
      end else if (mem_ack) begin
        if (got.size() == 0) got_adr = pc_crnt_adr;
        got.push_back(mem_rdata);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      logic e_req, e_valid, e_load;
      e_req   = !reset && started && !halted && !complete();
      e_valid = !reset && complete();
      e_load  = !reset && br_valid;
      check("mem_req", mem_req, e_req);
      check("pc_enable", pc_enable, e_req & mem_ack & ~br_valid);
      check("pc_load", pc_load, e_load);
      check("pc_nxt_adr", pc_nxt_adr, e_load ? br_target : 8'h00);
      check("mem_adr", mem_adr, pc_crnt_adr);
      check("instr_valid", instr_valid, e_valid);
      if (e_valid) begin
        check("instr_opcode", instr_opcode, got[0]);
        check("instr_operand", instr_operand, (got.size() > 1) ? got[1] : 8'h00);
        check("instr_adr", instr_adr, got_adr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1; mem_ack = 0; instr_ready = 0; br_valid = 0; br_target = '0; halt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // One-byte opcode at 0x00 with immediate ack
    mem[0] = 8'h05; mem_ack = 1;
    tick(); tick();
    reset = 0; settle();
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 8'h00);
    check("rst_operand", instr_operand, 8'h00);
    check("rst_adr", instr_adr, 8'h00);
    check("rst_req", mem_req, 0);
    check("rst_pcen", pc_enable, 0);
    check("rst_pcload", pc_load, 0);
    tick();
    check("s1_req", mem_req, 1);
    check("s1_pcen", pc_enable, 1);
    tick();
    check("s1_valid", instr_valid, 1);
    check("s1_opcode", instr_opcode, 8'h05);
    check("s1_operand", instr_operand, 8'h00);
    check("s1_adr", instr_adr, 8'h00);
    check("s1_pc", pc_crnt_adr, 8'h01);

    // Two-byte opcode at 0x10 with 3-cycle ack delay on each byte
    reset = 1; mem_ack = 0; tick(); reset = 0;
    mem[8'h10] = 8'h85; mem[8'h11] = 8'h3C;
    br_valid = 1; br_target = 8'h10; tick();
    br_valid = 0; settle();
    check("s2_adr_a", mem_adr, 8'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_wait_adr", mem_adr, 8'h10);
      check("s2_wait_req", mem_req, 1);
    end
    mem_ack = 1; settle();
    check("s2_pcen", pc_enable, 1);
    tick(); mem_ack = 0; settle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_wait2_adr", mem_adr, 8'h11);
    end
    mem_ack = 1; tick(); mem_ack = 0; settle();
    check("s2_valid", instr_valid, 1);
    check("s2_opcode", instr_opcode, 8'h85);
    check("s2_operand", instr_operand, 8'h3C);
    check("s2_adr", instr_adr, 8'h10);
    check("s2_pc", pc_crnt_adr, 8'h12);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", instr_valid, 1);
      check("hold_opcode", instr_opcode, 8'h85);
      check("hold_operand", instr_operand, 8'h3C);
      check("hold_req", mem_req, 0);
      check("hold_pc", pc_crnt_adr, 8'h12);
    end

    // Branch coincident with the immediate ack
    instr_ready = 1; tick(); instr_ready = 0;
    mem[8'h12] = 8'h9A; mem_ack = 1; tick();
    br_valid = 1; br_target = 8'h40; settle();
    check("br_pcload", pc_load, 1);
    check("br_pcen", pc_enable, 0);
    check("br_nxt", pc_nxt_adr, 8'h40);
    tick(); br_valid = 0; mem_ack = 0; settle();
    check("br_valid_after", instr_valid, 0);
    check("br_fetch_adr", mem_adr, 8'h40);
    check("br_req", mem_req, 1);

    // Two-byte opcode at 0xFF wraps to 0x00 for the immediate
    br_valid = 1; br_target = 8'hFF; tick(); br_valid = 0;
    mem[8'hFF] = 8'h81; mem[8'h00] = 8'h77; mem_ack = 1;
    tick(); settle();
    check("wrap_imm_adr", mem_adr, 8'h00);
    tick(); mem_ack = 0; settle();
    check("wrap_opcode", instr_opcode, 8'h81);
    check("wrap_operand", instr_operand, 8'h77);
    check("wrap_adr", instr_adr, 8'hFF);
    check("wrap_pc", pc_crnt_adr, 8'h01);

    // Halt during immediate fetch: hand-off completes, then halted
    instr_ready = 1; tick(); instr_ready = 0;
    mem[8'h01] = 8'hC2; mem[8'h02] = 8'h11; mem_ack = 1;
    tick(); halt = 1; tick(); mem_ack = 0; settle();
    check("halt_valid", instr_valid, 1);
    check("halt_opcode", instr_opcode, 8'hC2);
    check("halt_operand", instr_operand, 8'h11);
    check("halt_adr", instr_adr, 8'h01);
    instr_ready = 1; tick(); instr_ready = 0; settle();
    check("halted_req", mem_req, 0);
    check("halted_valid", instr_valid, 0);
    tick(); tick();
    check("halted_req2", mem_req, 0);
    check("halted_pc", pc_crnt_adr, 8'h03);
    br_valid = 1; br_target = 8'h20; settle();
    check("halted_brload", pc_load, 1);
    tick(); br_valid = 0; settle();
    check("resume_adr", mem_adr, 8'h20);
    check("resume_req", mem_req, 1);
    halt = 0;

    // Reset in the middle of a two-byte fetch
    mem[8'h20] = 8'h88; mem_ack = 1; tick();
    reset = 1; settle();
    check("midrst_req", mem_req, 0);
    check("midrst_pcen", pc_enable, 0);
    tick(); reset = 0; mem_ack = 0; settle();
    check("midrst_valid", instr_valid, 0);
    check("midrst_opcode", instr_opcode, 8'h00);
    check("midrst_operand", instr_operand, 8'h00);
    check("midrst_req", mem_req, 0);
    check("midrst_pc", pc_crnt_adr, 8'h00);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 4000; n++) begin
      tick();
      mem_ack     = ($urandom_range(0, 9) < 6);
      instr_ready = ($urandom_range(0, 9) < 5);
      br_valid    = ($urandom_range(0, 29) == 0);
      br_target   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 15) == 0) halt = ~halt;
      reset       = ($urandom_range(0, 249) == 0);
    end
    tick();
    reset = 0; br_valid = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
